// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state encoding,
// ALU / immediate-select codes and the decoded control bundle.
package ctrl_pkg;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_NOP    = 7'b0000000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [2:0] ALU_REG    = 3'd0;
  localparam logic [2:0] ALU_LUI    = 3'd1;
  localparam logic [2:0] ALU_BRANCH = 3'd2;
  localparam logic [2:0] ALU_JUMP   = 3'd3;
  localparam logic [2:0] ALU_AUIPC  = 3'd4;
  localparam logic [2:0] ALU_OPIMM  = 3'd5;
  localparam logic [2:0] ALU_MEM    = 3'd6;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [2:0] imm_sel;
    logic       alu_src;
    logic       alu_pc;
    logic       add_sum_reg;
    logic       reg_write;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  // An instruction with no asserted flag has nothing to execute (NOP-like).
  function automatic logic has_action(input ctrl_t c);
    return c.alu_src | c.alu_pc | c.add_sum_reg | c.reg_write |
           c.mem_rd | c.mem_wr | c.mem_to_reg | c.branch;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder; known_o flags opcodes present in the table
// (NOP included) so the control unit can detect illegal instructions.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output ctrl_t      ctrl_o,
  output logic       known_o
);

  always_comb begin
    ctrl_o  = '0;
    known_o = 1'b1;
    case (op_i)
      OPC_OPIMM: begin
        ctrl_o.alu_op = ALU_OPIMM;  ctrl_o.imm_sel = IMM_I;
        ctrl_o.alu_src = 1'b1;      ctrl_o.reg_write = 1'b1;
      end
      OPC_OP: begin
        ctrl_o.alu_op = ALU_REG;    ctrl_o.imm_sel = IMM_I;
        ctrl_o.reg_write = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.alu_op = ALU_LUI;    ctrl_o.imm_sel = IMM_U;
        ctrl_o.alu_src = 1'b1;      ctrl_o.reg_write = 1'b1;
      end
      OPC_SW: begin
        ctrl_o.alu_op = ALU_MEM;    ctrl_o.imm_sel = IMM_S;
        ctrl_o.alu_src = 1'b1;      ctrl_o.mem_wr = 1'b1;
      end
      OPC_LW: begin
        ctrl_o.alu_op = ALU_MEM;    ctrl_o.imm_sel = IMM_I;
        ctrl_o.alu_src = 1'b1;      ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_rd = 1'b1;       ctrl_o.mem_to_reg = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.alu_op = ALU_BRANCH; ctrl_o.imm_sel = IMM_B;
        ctrl_o.branch = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_o.alu_op = ALU_AUIPC;  ctrl_o.imm_sel = IMM_U;
        ctrl_o.alu_src = 1'b1;      ctrl_o.alu_pc = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.alu_op = ALU_JUMP;   ctrl_o.imm_sel = IMM_J;
        ctrl_o.alu_pc = 1'b1;       ctrl_o.reg_write = 1'b1;
        ctrl_o.branch = 1'b1;
      end
      OPC_JALR: begin
        ctrl_o.alu_op = ALU_JUMP;   ctrl_o.imm_sel = IMM_I;
        ctrl_o.alu_pc = 1'b1;       ctrl_o.add_sum_reg = 1'b1;
        ctrl_o.branch = 1'b1;
      end
      OPC_NOP: ;
      default: known_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with registered decode.
// Optional illegal-opcode trap (illegal_o, TRAP state) under CTRL_ILLEGAL_TRAP_EN.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W  = 4,
  parameter int IMM_SEL_W = 3,
  parameter int BOOT_WAIT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [6:0]           op_i,
  input  logic                 imem_ready_i,
  input  logic                 dmem_ready_i,
  output logic                 imem_req_o,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic [2:0]           state_o,
  output logic [ALU_OP_W-1:0]  alu_op_o,
  output logic [IMM_SEL_W-1:0] imm_select_o,
  output logic                 alu_src_o,
  output logic                 alu_pc_o,
  output logic                 add_sum_reg_o,
  output logic                 reg_write_o,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic                 mem_to_reg_o,
  output logic                 branch_o
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_o
`endif
);

  localparam logic [8:0] BOOT_WAIT_L = 9'(BOOT_WAIT);

  state_e     state_q, state_d;
  logic [7:0] boot_cnt_q, boot_cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  ctrl_t      dec_ctrl;
  logic       dec_known;
  logic       decoded_phase;

  ctrl_decoder u_decoder (
    .op_i    (op_i),
    .ctrl_o  (dec_ctrl),
    .known_o (dec_known)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      boot_cnt_q <= '0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      ctrl_q     <= ctrl_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    ctrl_d     = ctrl_q;
    case (state_q)
      ST_IDLE: begin
        if ({1'b0, boot_cnt_q} + 9'd1 >= BOOT_WAIT_L) state_d = ST_FETCH;
        else boot_cnt_d = boot_cnt_q + 8'd1;
      end
      ST_FETCH: if (imem_ready_i) state_d = ST_DECODE;
      ST_DECODE: begin
        ctrl_d = dec_ctrl;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!dec_known) state_d = ST_TRAP;
        else
`endif
        if (!dec_known || !has_action(dec_ctrl)) state_d = ST_FETCH;
        else state_d = ST_EXEC;
      end
      // Jumps that link (JAL) still need WB; pure control transfers finish here.
      ST_EXEC: begin
        if (ctrl_q.mem_rd || ctrl_q.mem_wr) state_d = ST_MEM;
        else if (ctrl_q.branch && !ctrl_q.reg_write) state_d = ST_FETCH;
        else state_d = ST_WB;
      end
      ST_MEM: if (dmem_ready_i) state_d = ctrl_q.reg_write ? ST_WB : ST_FETCH;
      ST_WB: state_d = ST_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    decoded_phase = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);
    imem_req_o    = (state_q == ST_FETCH);
    ir_write_o    = (state_q == ST_FETCH) && imem_ready_i;
    // The retiring state is the one handing control back to FETCH.
    pc_write_o    = (decoded_phase || state_q == ST_DECODE) && (state_d == ST_FETCH);
    alu_op_o      = '0;
    imm_select_o  = '0;
    alu_src_o     = 1'b0;
    alu_pc_o      = 1'b0;
    add_sum_reg_o = 1'b0;
    mem_to_reg_o  = 1'b0;
    if (decoded_phase) begin
      alu_op_o      = ALU_OP_W'(ctrl_q.alu_op);
      imm_select_o  = IMM_SEL_W'(ctrl_q.imm_sel);
      alu_src_o     = ctrl_q.alu_src;
      alu_pc_o      = ctrl_q.alu_pc;
      add_sum_reg_o = ctrl_q.add_sum_reg;
      mem_to_reg_o  = ctrl_q.mem_to_reg;
    end
    branch_o      = (state_q == ST_EXEC) && ctrl_q.branch;
    mem_rd_o      = (state_q == ST_MEM) && ctrl_q.mem_rd;
    mem_wr_o      = (state_q == ST_MEM) && ctrl_q.mem_wr;
    reg_write_o   = (state_q == ST_WB) && ctrl_q.reg_write;
  end

  assign state_o = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_o = (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-sequence model plus directed scenarios.
module tb_multicycle_control_unit;

  localparam int BW = 2;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [6:0] op_i;
  logic       imem_ready_i, dmem_ready_i;
  logic       imem_req_o, ir_write_o, pc_write_o;
  logic [2:0] state_o;
  logic [3:0] alu_op_o;
  logic [2:0] imm_select_o;
  logic       alu_src_o, alu_pc_o, add_sum_reg_o, reg_write_o;
  logic       mem_rd_o, mem_wr_o, mem_to_reg_o, branch_o;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_o;
`endif

  int total = 0;
  int bad   = 0;

  multicycle_control_unit #(.ALU_OP_W(4), .IMM_SEL_W(3), .BOOT_WAIT(BW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .op_i(op_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .imem_req_o(imem_req_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .state_o(state_o), .alu_op_o(alu_op_o), .imm_select_o(imm_select_o),
    .alu_src_o(alu_src_o), .alu_pc_o(alu_pc_o), .add_sum_reg_o(add_sum_reg_o),
    .reg_write_o(reg_write_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] alu; logic [2:0] imm;
    logic src, pc, asr, rw, rd, wr, m2r, br;
  } attr_t;

  function automatic attr_t attr_of(input logic [6:0] op);
    attr_t a = '0;
    case (op)
      7'b0010011: begin a.alu = 5; a.imm = 0; a.src = 1; a.rw = 1; end
      7'b0110011: begin a.alu = 0; a.imm = 0; a.rw = 1; end
      7'b0110111: begin a.alu = 1; a.imm = 3; a.src = 1; a.rw = 1; end
      7'b0100011: begin a.alu = 6; a.imm = 1; a.src = 1; a.wr = 1; end
      7'b0000011: begin a.alu = 6; a.imm = 0; a.src = 1; a.rw = 1; a.rd = 1; a.m2r = 1; end
      7'b1100011: begin a.alu = 2; a.imm = 2; a.br = 1; end
      7'b0010111: begin a.alu = 4; a.imm = 3; a.src = 1; a.pc = 1; a.rw = 1; end
      7'b1101111: begin a.alu = 3; a.imm = 4; a.pc = 1; a.rw = 1; a.br = 1; end
      7'b1100111: begin a.alu = 3; a.imm = 0; a.pc = 1; a.asr = 1; a.br = 1; end
      default: ;
    endcase
    return a;
  endfunction

  // Phases an instruction walks through, one letter per state.
  function automatic string seq_of(input logic [6:0] op);
    case (op)
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111: return "FDEW";
      7'b0100011: return "FDEM";
      7'b0000011: return "FDEMW";
      7'b1100011, 7'b1100111: return "FDE";
      7'b0000000: return "FD";
`ifdef CTRL_ILLEGAL_TRAP_EN
      default: return "FDT";
`else
      default: return "FD";
`endif
    endcase
  endfunction

  function automatic int st_code(input byte ph);
    case (ph)
      "F": return 1; "D": return 2; "E": return 3;
      "M": return 4; "W": return 5; "T": return 6;
      default: return 0;
    endcase
  endfunction

  byte   m_ph;
  string m_seq;
  int    m_idx, m_idle;
  attr_t m_attr;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_ph = "I"; m_idle = BW; m_seq = ""; m_idx = 0; m_attr = '0;
    end else begin
      case (m_ph)
        "I": if (m_idle <= 1) m_ph = "F"; else m_idle--;
        "F": if (imem_ready_i) begin m_ph = "D"; m_idx = 1; end
        "D": begin
          m_seq = seq_of(op_i); m_attr = attr_of(op_i); m_idx = 2;
          m_ph = (m_seq.len() > 2) ? m_seq[2] : "F";
        end
        "T": ;
        default: if (!(m_ph == "M" && !dmem_ready_i)) begin
          m_idx++;
          m_ph = (m_idx < m_seq.len()) ? m_seq[m_idx] : "F";
        end
      endcase
    end
  end

  string c_s;
  bit    c_last, c_dec;

  always @(negedge clk_i) begin
    c_s    = (m_ph == "D") ? seq_of(op_i) : m_seq;
    c_dec  = (m_ph == "E") || (m_ph == "M") || (m_ph == "W");
    c_last = (c_dec || m_ph == "D") && (m_idx == c_s.len() - 1) &&
             !(m_ph == "M" && !dmem_ready_i);
    chk("state",       state_o,       st_code(m_ph));
    chk("imem_req",    imem_req_o,    m_ph == "F");
    chk("ir_write",    ir_write_o,    (m_ph == "F") && imem_ready_i);
    chk("pc_write",    pc_write_o,    c_last);
    chk("alu_op",      alu_op_o,      c_dec ? m_attr.alu : 0);
    chk("imm_select",  imm_select_o,  c_dec ? m_attr.imm : 0);
    chk("alu_src",     alu_src_o,     c_dec && m_attr.src);
    chk("alu_pc",      alu_pc_o,      c_dec && m_attr.pc);
    chk("add_sum_reg", add_sum_reg_o, c_dec && m_attr.asr);
    chk("mem_to_reg",  mem_to_reg_o,  c_dec && m_attr.m2r);
    chk("branch",      branch_o,      (m_ph == "E") && m_attr.br);
    chk("mem_rd",      mem_rd_o,      (m_ph == "M") && m_attr.rd);
    chk("mem_wr",      mem_wr_o,      (m_ph == "M") && m_attr.wr);
    chk("reg_write",   reg_write_o,   (m_ph == "W") && m_attr.rw);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal",     illegal_o,     m_ph == "T");
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  // Starts just after a clock edge with the DUT in FETCH; ends the same way.
  task automatic do_instr(input logic [6:0] op, input int fw, input int mw, input int exp_lat);
    int cyc;
    int mleft;
    cyc = 0; mleft = mw; op_i = op;
    for (int i = 0; i < fw; i++) begin
      imem_ready_i = 1'b0; dmem_ready_i = 1'b1; step(); cyc++;
    end
    imem_ready_i = 1'b1; step(); cyc++;
    while (state_o != 3'd1 && cyc < 40) begin
      imem_ready_i = 1'b1;
      if (m_ph == "M") begin
        dmem_ready_i = (mleft == 0);
        if (mleft > 0) mleft--;
      end else dmem_ready_i = 1'b1;
      step(); cyc++;
    end
    chk($sformatf("latency op=%b", op), cyc, exp_lat);
    imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0; op_i = '0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    repeat (3) step();
    sample();
    chk("rst state", state_o, 0);
    chk("rst imem_req", imem_req_o, 0);
    chk("rst pc_write", pc_write_o, 0);
    chk("rst reg_write", reg_write_o, 0);
    step();

    // Boot wait
    rst_n_i = 1'b1;
    sample(); chk("boot c1 state", state_o, 0); step();
    sample(); chk("boot c2 state", state_o, 0); step();
    sample(); chk("boot fetch state", state_o, 1); chk("boot imem_req", imem_req_o, 1);
    step();

    // LW, zero wait
    op_i = 7'b0000011; imem_ready_i = 1'b1;
    sample(); chk("lw c1 ir_write", ir_write_o, 1); step();
    imem_ready_i = 1'b0;
    sample(); chk("lw c2 state", state_o, 2); chk("lw c2 mem_rd", mem_rd_o, 0); step();
    sample(); chk("lw c3 alu_op", alu_op_o, 6); step();
    dmem_ready_i = 1'b1;
    sample(); chk("lw c4 mem_rd", mem_rd_o, 1); chk("lw c4 pc_write", pc_write_o, 0); step();
    dmem_ready_i = 1'b0;
    sample(); chk("lw c5 reg_write", reg_write_o, 1); chk("lw c5 mem_to_reg", mem_to_reg_o, 1);
    chk("lw c5 pc_write", pc_write_o, 1); step();
    sample(); chk("lw c6 state", state_o, 1);

    // SW with three data wait cycles
    op_i = 7'b0100011; imem_ready_i = 1'b1; step();
    imem_ready_i = 1'b0; step(); step();
    for (int k = 0; k < 4; k++) begin
      dmem_ready_i = (k == 3);
      sample();
      chk($sformatf("sw m%0d mem_wr", k), mem_wr_o, 1);
      chk($sformatf("sw m%0d reg_write", k), reg_write_o, 0);
      chk($sformatf("sw m%0d pc_write", k), pc_write_o, k == 3);
      step();
    end
    dmem_ready_i = 1'b0;
    sample(); chk("sw after state", state_o, 1);

    // BRANCH
    op_i = 7'b1100011; imem_ready_i = 1'b1; step();
    imem_ready_i = 1'b0;
    sample(); chk("br c2 branch", branch_o, 0); step();
    sample(); chk("br c3 branch", branch_o, 1); chk("br c3 imm", imm_select_o, 2);
    chk("br c3 alu", alu_op_o, 2); chk("br c3 pc_write", pc_write_o, 1); step();
    sample(); chk("br c4 state", state_o, 1); chk("br c4 branch", branch_o, 0);
    step();

    // Instruction stream with fetch/data waits
    do_instr(7'b0010011, 0, 0, 4);
    do_instr(7'b0110011, 1, 0, 5);
    do_instr(7'b0110111, 0, 0, 4);
    do_instr(7'b0010111, 2, 0, 6);
    do_instr(7'b1101111, 0, 0, 4);
    do_instr(7'b1100111, 0, 0, 3);
    do_instr(7'b1100011, 1, 0, 4);
    do_instr(7'b0000000, 0, 0, 2);
    do_instr(7'b0000011, 0, 2, 7);
    do_instr(7'b0100011, 1, 1, 6);
    do_instr(7'b0000011, 0, 0, 5);

    // Reset during MEM of an LW
    op_i = 7'b0000011; imem_ready_i = 1'b1; step();
    imem_ready_i = 1'b0; step(); step();
    dmem_ready_i = 1'b0;
    sample(); chk("rstmem mem_rd before", mem_rd_o, 1);
    #2 rst_n_i = 1'b0;
    #1 chk("rstmem mem_rd after", mem_rd_o, 0); chk("rstmem state", state_o, 0);
    step();
    rst_n_i = 1'b1; dmem_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk($sformatf("rstmem k%0d reg_write", k), reg_write_o, 0);
      chk($sformatf("rstmem k%0d state", k), state_o, (k < 2) ? 0 : 1);
      step();
    end
    dmem_ready_i = 1'b0;

    // Unlisted opcode
    op_i = 7'b1111111; imem_ready_i = 1'b1;
    sample(); chk("ill c1 state", state_o, 1); step();
    imem_ready_i = 1'b0;
    sample(); chk("ill c2 state", state_o, 2); step();
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 5; k++) begin
      imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
      sample();
      chk($sformatf("trap k%0d state", k), state_o, 6);
      chk($sformatf("trap k%0d illegal", k), illegal_o, 1);
      chk($sformatf("trap k%0d imem_req", k), imem_req_o, 0);
      step();
    end
    rst_n_i = 1'b0;
    #1 chk("trap rst illegal", illegal_o, 0); chk("trap rst state", state_o, 0);
    step(); rst_n_i = 1'b1; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    repeat (3) step();
`else
    sample(); chk("ill c3 state", state_o, 1);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 4: ALU operation code width, minimum 4; codes are zero-extended.
REQ-002 SHALL have parameter IMM_SEL_W, default 3: immediate-format select width, minimum 3.
REQ-003 SHALL have parameter BOOT_WAIT, default 2: number of IDLE cycles after reset release, range 0..255.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_n_i in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: op_i in 7 opcode from the instruction register; imem_ready_i in 1 fetch done; dmem_ready_i in 1 data access done.
REQ-006 SHALL have ports: imem_req_o out 1; ir_write_o out 1; pc_write_o out 1; state_o out 3 current state.
REQ-007 SHALL have ports: alu_op_o out ALU_OP_W; imm_select_o out IMM_SEL_W.
REQ-008 SHALL have ports, all out 1: alu_src_o, alu_pc_o, add_sum_reg_o, reg_write_o, mem_rd_o, mem_wr_o, mem_to_reg_o, branch_o.
REQ-009 SHALL have port illegal_o out 1, present only with CTRL_ILLEGAL_TRAP_EN.

Function
REQ-010 SHALL use states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; state_o shows the current state.
REQ-011 SHALL handle IDLE: count BOOT_WAIT cycles, then enter FETCH; BOOT_WAIT=0 enters FETCH on the first clock edge.
REQ-012 SHALL handle FETCH: hold imem_req_o=1 until imem_ready_i=1; in that cycle pulse ir_write_o and enter DECODE.
REQ-013 SHALL latch decode signals from op_i in DECODE into registers; decoded outputs SHALL be driven from those registers in EXEC, MEM and WB, and SHALL be 0 in IDLE, FETCH and DECODE.
REQ-014 SHALL use this decode table (alu_op, imm_sel, asserted flags):
  0010011 OP-IMM: 5, 0, alu_src+reg_write.
  0110011 OP: 0, 0, reg_write.
  0110111 LUI: 1, 3, alu_src+reg_write.
  0100011 SW: 6, 1, alu_src+mem_wr.
  0000011 LW: 6, 0, alu_src+reg_write+mem_rd+mem_to_reg.
  1100011 BRANCH: 2, 2, branch.
  0010111 AUIPC: 4, 3, alu_src+alu_pc+reg_write.
  1101111 JAL: 3, 4, alu_pc+reg_write+branch.
  1100111 JALR: 3, 0, alu_pc+add_sum_reg+branch.
  0000000 NOP: all zero.
REQ-015 SHALL assert branch_o only in EXEC; mem_rd_o/mem_wr_o only in MEM; reg_write_o only in WB, one cycle per instruction.
REQ-016 SHALL sequence DECODE->FETCH for NOP; EXEC->MEM for LW/SW; EXEC->WB for OP-IMM, OP, LUI, AUIPC, JAL; EXEC->FETCH for BRANCH and JALR; MEM->WB for LW; MEM->FETCH for SW; WB->FETCH.
REQ-017 SHALL hold the MEM state with its strobes asserted until dmem_ready_i=1; dmem_ready_i SHALL be ignored outside MEM, and imem_ready_i outside FETCH.
REQ-018 SHALL pulse pc_write_o for exactly one cycle, in the final state of each instruction, coincident with the transition to FETCH.
REQ-019 SHALL give zero-wait latency, FETCH entry to next FETCH entry, of: NOP 2; BRANCH/JALR 3; OP/OP-IMM/LUI/AUIPC/JAL/SW 4; LW 5. Each ready wait cycle adds one cycle.

Reset
REQ-020 SHALL, while rst_n_i=0, force state IDLE, clear the boot counter and decode registers, and drive every output 0, including illegal_o.
REQ-021 SHALL, on reset asserted mid-instruction, drop all strobes immediately with no completion; after release, REQ-011 applies again.

Configuration
REQ-022 SHALL, with CTRL_ILLEGAL_TRAP_EN defined, send any opcode not in REQ-014 from DECODE to TRAP, driving illegal_o=1 and all other outputs 0; TRAP SHALL be left only by reset.
REQ-023 SHALL, without CTRL_ILLEGAL_TRAP_EN, omit illegal_o and the TRAP state and treat unlisted opcodes as NOP.

Structure
REQ-024 SHALL place in package ctrl_pkg: the opcode constants, the state encoding, the ALU op codes (0..6) and the immediate-select codes (0..4).
REQ-025 SHALL implement the REQ-014 table in a combinational sub-module ctrl_decoder, instantiated once and feeding the DECODE-stage registers.

Verification
REQ-026 SHALL cover reset release with BOOT_WAIT=2: state_o=0 for 2 cycles, then 1 with imem_req_o=1.
REQ-027 SHALL cover op_i=0000011 with zero wait: exactly 5 cycles; mem_rd_o=1 in cycle 4; reg_write_o=1 and mem_to_reg_o=1 in cycle 5; pc_write_o=1 in cycle 5.
REQ-028 SHALL cover op_i=0100011 with dmem_ready_i low for 3 cycles: mem_wr_o held for 4 cycles, no reg_write_o, pc_write_o on the 4th.
REQ-029 SHALL cover op_i=1100011: branch_o=1, imm_select_o=2, alu_op_o=2 in cycle 3 only; next cycle state_o=1.
REQ-030 SHALL cover op_i=1111111 with the macro defined: state_o=6 and illegal_o=1 persist until rst_n_i=0; without the macro, FETCH is re-entered after 2 cycles.
REQ-031 SHALL cover rst_n_i pulsed low during MEM of an LW: mem_rd_o falls in the same cycle, and reg_write_o is never asserted.
